// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg -- shared constants for the 7-segment scan driver.
//   Glyph codes are active-high {g,f,e,d,c,b,a}.
//   SEG7_NUM_DIGITS : number of multiplexed digits (fixed at 4).
//   SEG_BLANK       : all segments off.
//   digit_onehot()  : digit index -> one-hot digit enable.
// ---------------------------------------------------------------------------
package seg7_pkg;

   localparam int SEG7_NUM_DIGITS = 4;

   localparam logic [6:0] SEG_BLANK = 7'h00;
   localparam logic [6:0] GLYPH_0   = 7'h3F;
   localparam logic [6:0] GLYPH_1   = 7'h06;
   localparam logic [6:0] GLYPH_2   = 7'h5B;
   localparam logic [6:0] GLYPH_3   = 7'h4F;
   localparam logic [6:0] GLYPH_4   = 7'h66;
   localparam logic [6:0] GLYPH_5   = 7'h6D;
   localparam logic [6:0] GLYPH_6   = 7'h7D;
   localparam logic [6:0] GLYPH_7   = 7'h07;
   localparam logic [6:0] GLYPH_8   = 7'h7F;
   localparam logic [6:0] GLYPH_9   = 7'h6F;

   function automatic logic [3:0] digit_onehot(input logic [1:0] idx);
      return 4'b0001 << idx;
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// ---------------------------------------------------------------------------
// seg7_decode -- combinational BCD to 7-segment glyph mapping.
//   i_code  [3:0] : BCD code; 10..15 decode to blank
//   i_blank       : force blank (leading-zero suppression)
//   o_seg   [6:0] : active-high segments {g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [3:0] i_code,
   input  logic       i_blank,
   output logic [6:0] o_seg
);

   // Glyph lookup with blank override
   always_comb begin
      o_seg = SEG_BLANK;
      if (i_blank) begin
         o_seg = SEG_BLANK;
      end else begin
         case (i_code)
            4'd0:    o_seg = GLYPH_0;
            4'd1:    o_seg = GLYPH_1;
            4'd2:    o_seg = GLYPH_2;
            4'd3:    o_seg = GLYPH_3;
            4'd4:    o_seg = GLYPH_4;
            4'd5:    o_seg = GLYPH_5;
            4'd6:    o_seg = GLYPH_6;
            4'd7:    o_seg = GLYPH_7;
            4'd8:    o_seg = GLYPH_8;
            4'd9:    o_seg = GLYPH_9;
            default: o_seg = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// seg7_scan_driver -- 4-digit multiplexed 7-segment driver with PWM dimming.
//   clk, rst_n         : clock, async active-low reset
//   ena                : run enable (low freezes scan, blanks outputs)
//   bcd_in[15:0]/dp_in : digit data, captured into shadow on load
//   brightness[2:0]    : on-time (brightness+1)/8, applied at next PWM tick
//   seg_out, dp_out    : registered active-high segments / decimal point
//   dig_sel[3:0]       : registered one-hot digit enable
//   frame_done         : one-cycle pulse on the last-digit -> digit-0 wrap
// Optional build macro: SEG7_LZB_EN enables leading-zero blanking.
// Outputs are registered from the current counter state, so the visible
// scan lags the counters by one clock; slot/frame lengths are unaffected.
// ---------------------------------------------------------------------------
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter logic [15:0] SCAN_DIV   = 16'd1250,
   parameter int          NUM_DIGITS = SEG7_NUM_DIGITS
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ena,
   input  logic [15:0] bcd_in,
   input  logic [3:0]  dp_in,
   input  logic        load,
   input  logic [2:0]  brightness,
   output logic [6:0]  seg_out,
   output logic        dp_out,
   output logic [3:0]  dig_sel,
   output logic        frame_done
);

   localparam logic [1:0] LAST_IDX = 2'(NUM_DIGITS - 1);

   logic [15:0] r_presc;
   logic [2:0]  r_pwm;
   logic [1:0]  r_idx;
   logic [2:0]  r_bright;
   logic [15:0] r_shadow_bcd;
   logic [3:0]  r_shadow_dp;
   logic        r_pending;
   logic [15:0] r_disp_bcd;
   logic [3:0]  r_disp_dp;
   logic [6:0]  r_seg;
   logic        r_dp;
   logic [3:0]  r_dig;
   logic        r_frame;

   logic        w_tick;
   logic        w_slot_end;
   logic        w_wrap;
   logic        w_on;
   logic [3:0]  w_digit;
   logic        w_blank;
   logic [6:0]  w_seg;

   assign w_tick     = ena && (r_presc == (SCAN_DIV - 16'd1));
   assign w_slot_end = w_tick && (r_pwm == 3'd7);
   assign w_wrap     = w_slot_end && (r_idx == LAST_IDX);
   // First cycle of a slot is dead time; otherwise on while pwm <= latched level
   assign w_on       = !((r_presc == 16'd0) && (r_pwm == 3'd0)) && (r_pwm <= r_bright);
   assign w_digit    = r_disp_bcd[{r_idx, 2'b00} +: 4];

   // Leading-zero blanking for digits above the first nonzero one
   always_comb begin
      w_blank = 1'b0;
`ifdef SEG7_LZB_EN
      case (r_idx)
         2'd3:    w_blank = (r_disp_bcd[15:12] == 4'd0);
         2'd2:    w_blank = (r_disp_bcd[15:8]  == 8'd0);
         2'd1:    w_blank = (r_disp_bcd[15:4]  == 12'd0);
         default: w_blank = 1'b0;
      endcase
`endif
   end

   seg7_decode u_decode (
      .i_code  (w_digit),
      .i_blank (w_blank),
      .o_seg   (w_seg)
   );

   // Prescaler, PWM counter, digit index; brightness latched each tick
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_presc  <= 16'd0;
         r_pwm    <= 3'd0;
         r_idx    <= 2'd0;
         r_bright <= 3'd0;
      end else if (w_tick) begin
         r_presc  <= 16'd0;
         r_pwm    <= r_pwm + 3'd1;
         r_bright <= brightness;
         if (w_slot_end) begin
            r_idx <= (r_idx == LAST_IDX) ? 2'd0 : r_idx + 2'd1;
         end else begin
            r_idx <= r_idx;
         end
      end else if (ena) begin
         r_presc <= r_presc + 16'd1;
      end else begin
         r_presc <= r_presc;
      end
   end

   // Shadow capture and frame-boundary transfer; a load on the wrap cycle wins
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shadow_bcd <= 16'd0;
         r_shadow_dp  <= 4'd0;
         r_pending    <= 1'b0;
         r_disp_bcd   <= 16'd0;
         r_disp_dp    <= 4'd0;
      end else begin
         if (load) begin
            r_shadow_bcd <= bcd_in;
            r_shadow_dp  <= dp_in;
         end else begin
            r_shadow_bcd <= r_shadow_bcd;
            r_shadow_dp  <= r_shadow_dp;
         end
         if (w_wrap && (r_pending || load)) begin
            r_disp_bcd <= load ? bcd_in : r_shadow_bcd;
            r_disp_dp  <= load ? dp_in  : r_shadow_dp;
            r_pending  <= 1'b0;
         end else if (load) begin
            r_pending  <= 1'b1;
         end else begin
            r_pending  <= r_pending;
         end
      end
   end

   // Registered display outputs, forced low while disabled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_seg   <= 7'd0;
         r_dp    <= 1'b0;
         r_dig   <= 4'd0;
         r_frame <= 1'b0;
      end else if (ena) begin
         r_seg   <= w_seg;
         r_dp    <= r_disp_dp[r_idx];
         r_dig   <= w_on ? digit_onehot(r_idx) : 4'd0;
         r_frame <= w_wrap;
      end else begin
         r_seg   <= 7'd0;
         r_dp    <= 1'b0;
         r_dig   <= 4'd0;
         r_frame <= 1'b0;
      end
   end

   assign seg_out    = r_seg;
   assign dp_out     = r_dp;
   assign dig_sel    = r_dig;
   assign frame_done = r_frame;

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter SCAN_DIV, default 16'd1250, clk cycles per PWM tick; legal range 2..65535.
REQ-002 Parameter NUM_DIGITS, default 4, number of multiplexed digits; fixed at 4 in this revision.
REQ-003 clk  input  1  single clock, rising-edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 ena  input  1  design enable; high = run.
REQ-006 bcd_in  input  16  four BCD nibbles; [3:0] = digit 0 (rightmost).
REQ-007 dp_in  input  4  decimal-point request per digit.
REQ-008 load  input  1  one-cycle strobe capturing bcd_in/dp_in into the shadow register.
REQ-009 brightness  input  3  duty level; 0 = 1/8 on-time, 7 = 8/8 on-time.
REQ-010 seg_out  output  7  active-high segments {g,f,e,d,c,b,a}.
REQ-011 dp_out  output  1  active-high decimal point.
REQ-012 dig_sel  output  4  one-hot active-high digit enable.
REQ-013 frame_done  output  1  one-cycle pulse at end of each full scan.

Function
REQ-014 The prescaler shall count 0..SCAN_DIV-1 and wrap; its terminal count is one PWM tick.
REQ-015 A 3-bit pwm_cnt shall increment on each tick; digit index advances 0->1->2->3->0 on the tick where pwm_cnt wraps 7->0.
REQ-016 Digit slot length shall be exactly 8*SCAN_DIV cycles; full frame 32*SCAN_DIV cycles.
REQ-017 dig_sel shall be one-hot on the current index only while pwm_cnt <= brightness, else 4'b0000.
REQ-018 dig_sel shall be 4'b0000 for the first clk cycle of every digit slot (dead time against ghosting).
REQ-019 brightness shall be sampled continuously; a change takes effect at the next tick.
REQ-020 Codes 0..9 shall decode to standard glyphs (0=7'h3F, 1=7'h06, ..., 9=7'h6F); codes 10..15 decode to 7'h00.
REQ-021 seg_out/dp_out shall be registered and reflect the display register entry for the current index, aligned with dig_sel.
REQ-022 load shall copy bcd_in/dp_in into the shadow register and set pending.
REQ-023 When pending, the shadow shall transfer to the display register on the digit 3->0 wrap and pending clears; display never changes mid-frame.
REQ-024 load coincident with the wrap cycle shall have its new data transferred at that wrap (load wins).
REQ-025 Multiple loads within one frame: last one wins.
REQ-026 frame_done shall pulse high for one cycle on the 3->0 wrap cycle.
REQ-027 ena low shall freeze prescaler, pwm_cnt, index; force seg_out, dp_out, dig_sel, frame_done to 0; load still captured into shadow.

Reset
REQ-028 rst_n low shall asynchronously clear prescaler, pwm_cnt, index, shadow, display register, pending, and all outputs to 0.
REQ-029 Reset deassertion mid-frame shall restart scanning at digit 0, prescaler 0, with display all zeros.

Configuration
REQ-030 With SEG7_LZB_EN defined, leading zeros in digits 3..1 shall be blanked (seg_out 7'h00) up to the first nonzero digit; digit 0 always shown; dp_out unaffected.
REQ-031 Without SEG7_LZB_EN, every digit shall display its glyph including leading zeros.

Structure
REQ-032 Package seg7_pkg shall hold glyph constants, the blank code, and the NUM_DIGITS constant.
REQ-033 Sub-module seg7_decode shall implement the combinational 4-bit-to-7-segment mapping.

Verification (SCAN_DIV=4)
REQ-034 Reset, ena=1, no load -> digit 0 selected after 1 dead cycle, seg_out=7'h3F, dig_sel=4'b0001 for brightness=7.
REQ-035 load bcd_in=16'h1234 at cycle 10 -> display unchanged until wrap at cycle 128, then digit 0 shows 7'h66, digit 3 shows 7'h06; frame_done pulses at 128.
REQ-036 brightness=0 -> dig_sel high for 4 of every 32 slot cycles minus dead cycle; brightness=3 -> 16 cycles.
REQ-037 SEG7_LZB_EN, load 16'h0005 -> digits 3..1 seg_out 7'h00, digit 0 7'h6D; without macro digits 3..1 show 7'h3F.
REQ-038 ena low for 20 cycles mid-slot -> all outputs 0, counters hold; on ena high scanning resumes at same index and count.
REQ-039 Reset asserted mid-frame with pending load -> outputs 0 immediately, pending lost, restart at digit 0 showing 0.
